dedup_input_arbiter: RTL and testbench

// Round-robin arbiter sharing the single data_in port of the duplicate-filter buffer among N_REQ

---
 rtl/dedup_input_arbiter_if.sv | 33 +++
 rtl/dedup_input_arbiter.sv | 116 +++++++++++
 tb/tb_dedup_input_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dedup_input_arbiter_if.sv
// Handshake bundle between N_REQ producers, the arbiter and the duplicate filter's input.
//   req_valid_in  / req_data_in / req_ready_out : per-requester valid/ready channel
//   data_out / data_valid_out / data_ready_in   : single output word towards the filter
// Modport master is the arbiter side; modport slave is the producer/filter side.
interface dedup_input_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid_in;
    logic [N_REQ*DATA_W-1:0] req_data_in;
    logic [N_REQ-1:0]        req_ready_out;
    logic [DATA_W-1:0]       data_out;
    logic                    data_valid_out;
    logic                    data_ready_in;

    modport master (
        input  req_valid_in,
        input  req_data_in,
        input  data_ready_in,
        output req_ready_out,
        output data_out,
        output data_valid_out
    );

    modport slave (
        output req_valid_in,
        output req_data_in,
        output data_ready_in,
        input  req_ready_out,
        input  data_out,
        input  data_valid_out
    );
endinterface

// File: rtl/dedup_input_arbiter.sv
// Round-robin arbiter feeding the duplicate-filter input from N_REQ producers.
// Grants one requester at a time for up to BURST_MAX beats, with a one-entry registered
// output stage that absorbs downstream backpressure.
//   clk_in        : clock, rising edge
//   reset_in      : asynchronous active-low reset
//   bus           : requester and filter handshakes (see dedup_input_arbiter_if)
//   grant_id_out  : index of the current/last granted requester
//   busy_out      : high while a grant is active
module dedup_input_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    dedup_input_arbiter_if.master    bus,
    output logic [$clog2(N_REQ)-1:0] grant_id_out,
    output logic                     busy_out
);
    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned BW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [BW-1:0]     beat_cnt;

    logic              slot_free;
    logic              xfer;
    logic              last_beat;
    logic              scan_hit;
    logic [GW-1:0]     scan_id;
    logic [GW-1:0]     next_ptr;
    logic [DATA_W-1:0] grant_word;
    int unsigned       idx;

    // Output register can take a new word when empty or draining this cycle.
    assign slot_free  = !bus.data_valid_out || bus.data_ready_in;
    assign grant_word = bus.req_data_in[32'(grant_id_out) * DATA_W +: DATA_W];
    assign xfer       = (state == GRANT) && slot_free && bus.req_valid_in[grant_id_out];
    assign last_beat  = (beat_cnt == BW'(BURST_MAX - 1));
    // Explicit wrap so non-power-of-2 N_REQ never yields an out-of-range index.
    assign next_ptr   = (grant_id_out == GW'(N_REQ - 1)) ? '0 : grant_id_out + GW'(1);

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = rr_ptr;
        idx      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!scan_hit && bus.req_valid_in[idx]) begin
                scan_hit = 1'b1;
                scan_id  = GW'(idx);
            end
        end
    end

    // Only the granted requester ever sees ready.
    always_comb begin
        bus.req_ready_out = '0;
        if ((state == GRANT) && slot_free) begin
            bus.req_ready_out[grant_id_out] = 1'b1;
        end
    end

    // Grant FSM plus output stage.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            beat_cnt           <= '0;
            grant_id_out       <= '0;
            busy_out           <= 1'b0;
            bus.data_out       <= '0;
            bus.data_valid_out <= 1'b0;
        end else begin
            // Output stage runs independently of the FSM so a held word survives release.
            if (xfer) begin
                bus.data_out       <= grant_word;
                bus.data_valid_out <= 1'b1;
            end else if (bus.data_valid_out && bus.data_ready_in) begin
                bus.data_valid_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        grant_id_out <= scan_id;
                        beat_cnt     <= '0;
                        busy_out     <= 1'b1;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                    if ((xfer && last_beat) || !bus.req_valid_in[grant_id_out]) begin
                        rr_ptr   <= next_ptr;
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dedup_input_arbiter.sv
// Self-checking bench for dedup_input_arbiter: cycle table, directed corner sequences,
// a 3-requester instance, and randomized traffic against a transaction-level model.
module tb_dedup_input_arbiter;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned BURST_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] grant3;
    logic       busy3;

    dedup_input_arbiter_if #(.DATA_W(DATA_W), .N_REQ(N_REQ)) bus ();
    dedup_input_arbiter_if #(.DATA_W(DATA_W), .N_REQ(3))     bus3 ();

    dedup_input_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .BURST_MAX(BURST_MAX)) u_dut (
        .clk_in       (clk),
        .reset_in     (rst_n),
        .bus          (bus),
        .grant_id_out (grant),
        .busy_out     (busy)
    );

    dedup_input_arbiter #(.DATA_W(DATA_W), .N_REQ(3), .BURST_MAX(BURST_MAX)) u_dut3 (
        .clk_in       (clk),
        .reset_in     (rst_n),
        .bus          (bus3),
        .grant_id_out (grant3),
        .busy_out     (busy3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] v, input logic [7:0] w, input logic dr);
        bus.req_valid_in  = v;
        bus.req_data_in   = {4{w}};
        bus.data_ready_in = dr;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(4'b0, 8'h00, 1'b0);
        bus3.req_valid_in  = '0;
        bus3.req_data_in   = '0;
        bus3.data_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Round-robin rule: first set bit scanning from p upward, modulo N_REQ.
    function automatic int scan(input logic [3:0] v, input int p);
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (v[(p + k) % int'(N_REQ)]) return (p + k) % int'(N_REQ);
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0] valid;
        logic [7:0] word;
        logic       dready;
        logic [3:0] exp_ready;
        logic       exp_dv;
        logic [7:0] exp_dout;
        logic [1:0] exp_grant;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [11];

    task automatic run_table();
        tbl[0]  = '{4'b0100, 8'h11, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[1]  = '{4'b0100, 8'h11, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b1};
        tbl[2]  = '{4'b0100, 8'h22, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b1};
        tbl[3]  = '{4'b0100, 8'h33, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1};
        tbl[4]  = '{4'b0000, 8'h33, 1'b1, 4'b0100, 1'b0, 8'h33, 2'd2, 1'b0};
        tbl[5]  = '{4'b1101, 8'h44, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd3, 1'b1};
        tbl[6]  = '{4'b0000, 8'h44, 1'b1, 4'b1000, 1'b0, 8'h33, 2'd3, 1'b0};
        tbl[7]  = '{4'b0101, 8'h44, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd0, 1'b1};
        tbl[8]  = '{4'b0000, 8'h44, 1'b1, 4'b0001, 1'b0, 8'h33, 2'd0, 1'b0};
        tbl[9]  = '{4'b0100, 8'h44, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b1};
        tbl[10] = '{4'b0000, 8'h44, 1'b1, 4'b0100, 1'b0, 8'h33, 2'd2, 1'b0};
        apply_reset();
        for (int r = 0; r < 11; r++) begin
            if (r != 0) @(negedge clk);
            set_in(tbl[r].valid, tbl[r].word, tbl[r].dready);
            #1;
            check($sformatf("tbl%0d_ready", r), int'(bus.req_ready_out), int'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_dv", r),    int'(bus.data_valid_out), int'(tbl[r].exp_dv));
            check($sformatf("tbl%0d_dout", r),  int'(bus.data_out),       int'(tbl[r].exp_dout));
            check($sformatf("tbl%0d_grant", r), int'(grant),              int'(tbl[r].exp_grant));
            check($sformatf("tbl%0d_busy", r),  int'(busy),               int'(tbl[r].exp_busy));
        end
    endtask

    // All requesters valid on both instances: grants rotate, 4 beats, one idle cycle.
    task automatic run_saturate();
        int exp_b;
        apply_reset();
        set_in(4'b1111, 8'h5A, 1'b1);
        bus3.req_valid_in  = 3'b111;
        bus3.req_data_in   = {3{8'hA5}};
        bus3.data_ready_in = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            exp_b = ((k % 5) != 4) ? 1 : 0;
            check($sformatf("sat%0d_busy", k), int'(busy), exp_b);
            check($sformatf("sat%0d_busy3", k), int'(busy3), exp_b);
            if (exp_b == 1) begin
                check($sformatf("sat%0d_grant", k), int'(grant), (k / 5) % 4);
                check($sformatf("sat%0d_grant3", k), int'(grant3), (k / 5) % 3);
                check($sformatf("sat%0d_ready", k), int'(bus.req_ready_out), 1 << ((k / 5) % 4));
            end else begin
                check($sformatf("sat%0d_ready_idle", k), int'(bus.req_ready_out), 0);
            end
        end
    endtask

    // Mid-burst backpressure holds the output word and withdraws ready.
    task automatic run_backpressure();
        apply_reset();
        set_in(4'b0010, 8'hA0, 1'b1);
        @(posedge clk); #1;
        check("bp_grant", int'(grant), 1);
        @(negedge clk); #1;
        check("bp_ready0", int'(bus.req_ready_out), 2);
        @(posedge clk); #1;
        check("bp_dout0", int'(bus.data_out), 'hA0);
        @(negedge clk);
        set_in(4'b0010, 8'hA1, 1'b0);
        #1;
        check("bp_ready_stall", int'(bus.req_ready_out), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_dv", i), int'(bus.data_valid_out), 1);
            check($sformatf("bp_hold%0d_dout", i), int'(bus.data_out), 'hA0);
            check($sformatf("bp_hold%0d_ready", i), int'(bus.req_ready_out), 0);
        end
        @(negedge clk);
        bus.data_ready_in = 1'b1;
        #1;
        check("bp_ready_resume", int'(bus.req_ready_out), 2);
        @(posedge clk); #1;
        check("bp_dout1", int'(bus.data_out), 'hA1);
        @(negedge clk);
        set_in(4'b0010, 8'hA2, 1'b1);
        @(posedge clk); #1;
        check("bp_dout2", int'(bus.data_out), 'hA2);
        @(negedge clk);
        set_in(4'b0000, 8'h00, 1'b1);
        @(posedge clk); #1;
        check("bp_release", int'(busy), 0);
        check("bp_drain", int'(bus.data_valid_out), 0);
    endtask

    // Asynchronous reset mid-burst, then the scan restarts from requester 0.
    task automatic run_async_reset();
        apply_reset();
        set_in(4'b0010, 8'hC1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_in(4'b0000, 8'h00, 1'b1);
        @(negedge clk);
        set_in(4'b0100, 8'hB0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("ar_pre_dv", int'(bus.data_valid_out), 1);
        check("ar_pre_grant", int'(grant), 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_dv", int'(bus.data_valid_out), 0);
        check("ar_dout", int'(bus.data_out), 0);
        check("ar_ready", int'(bus.req_ready_out), 0);
        check("ar_grant", int'(grant), 0);
        check("ar_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(4'b1010, 8'hB1, 1'b1);
        @(posedge clk); #1;
        check("ar_first_grant", int'(grant), 1);
        check("ar_no_stale", int'(bus.data_valid_out), 0);
        @(posedge clk); #1;
        check("ar_first_word", int'(bus.data_out), 'hB1);
        @(negedge clk);
        set_in(4'b0000, 8'h00, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    // Random traffic: per-requester ordered words, round-robin fairness, burst bound.
    task automatic run_random();
        logic [7:0] q   [4][$];
        logic [7:0] exq [4][$];
        logic [3:0] v, acc, pend_v;
        logic       fire, pend, exp_free;
        logic [7:0] ow;
        int         ptr, beats, left, id, nw;
        apply_reset();
        left = 0;
        for (int i = 0; i < 4; i++) begin
            nw = 12 + int'($urandom_range(9));
            for (int s = 0; s < nw; s++) q[i].push_back({2'(i), 6'(s)});
            exq[i] = q[i];
            left += nw;
        end
        v = '0; acc = '0; fire = 1'b0; pend = 1'b0; pend_v = '0; ow = '0;
        ptr = 0; beats = 0;
        for (int cyc = 0; cyc < 4000 && left > 0; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) void'(q[i].pop_front());
            end
            if (fire) begin
                id = int'(ow[7:6]);
                if (exq[id].size() == 0) begin
                    check("rnd_extra_word", exq[id].size(), 1);
                end else begin
                    check("rnd_order", int'(ow), int'(exq[id].pop_front()));
                    left--;
                end
            end
            if (pend) begin
                check("rnd_busy_after_idle", int'(busy), 1);
                check("rnd_grant", int'(grant), scan(pend_v, ptr));
                ptr = (int'(grant) + 1) % int'(N_REQ);
                beats = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (!(v[i] && !acc[i])) v[i] = (q[i].size() > 0) && ($urandom_range(3) != 0);
                bus.req_data_in[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
            end
            bus.req_valid_in  = v;
            bus.data_ready_in = ($urandom_range(3) != 0);
            #1;
            exp_free = !bus.data_valid_out || bus.data_ready_in;
            check("rnd_ready", int'(bus.req_ready_out), (busy && exp_free) ? (1 << grant) : 0);
            acc  = v & bus.req_ready_out;
            fire = bus.data_valid_out && bus.data_ready_in;
            ow   = bus.data_out;
            if (acc != 0) begin
                beats += $countones(acc);
                check("rnd_burst_le_max", int'(beats <= int'(BURST_MAX)), 1);
            end
            pend   = !busy && (v != 0);
            pend_v = v;
        end
        check("rnd_drained", left, 0);
        @(negedge clk);
        set_in(4'b0000, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(4'b0, 8'h00, 1'b0);
        bus3.req_valid_in  = '0;
        bus3.req_data_in   = '0;
        bus3.data_ready_in = 1'b0;
        #1;
        check("rst_dv", int'(bus.data_valid_out), 0);
        check("rst_dout", int'(bus.data_out), 0);
        check("rst_ready", int'(bus.req_ready_out), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_busy3", int'(busy3), 0);
        run_table();
        run_saturate();
        run_backpressure();
        run_async_reset();
        run_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
